opram_sat2_updater: RTL
=======================

Name: opram_sat2_updater

Overview:
- Update engine for a 32-entry x 2-bit multi-read-port op-RAM that holds 2-bit saturating counters.
- Sits directly upstream of the RAM's single write port: queues increment/decrement requests from up to 2 lanes per cycle, then performs a pipelined read-modify-write.
- Uses one RAM read port for the modify step and owns WEN/AW/DI exclusively.
- After reset, walks all 32 entries to INIT_VAL before accepting updates.

Parameters:
- FIFO_DEPTH, 8, request queue entries; power of two, >=2.
- INIT_VAL, 2'b01, value written to every RAM entry during post-reset init.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous active-high reset.
- upd_valid  input  2  per-lane request valid; lane 0 is older.
- upd_idx0  input  5  lane 0 counter index.
- upd_idx1  input  5  lane 1 counter index.
- upd_inc  input  2  per-lane direction: 1 = increment, 0 = decrement.
- upd_ready  output  1  both lanes may enqueue this cycle.
- init_done  output  1  init walk finished.
- busy  output  1  FIFO, S1 or S2 holds work.
- ram_a  output  5  RAM read address for RMW.
- ram_q  input  2  RAM read data; combinational from ram_a.
- ram_wen  output  1  RAM write enable.
- ram_aw  output  5  RAM write address.
- ram_di  output  2  RAM write data.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RST).
- Reset (RST=1 at posedge):
  - state <= INIT, init_cnt <= 0, FIFO emptied, S1/S2 valid cleared.
  - Outputs in the cycle after reset: init_done=0, upd_ready=0, busy=0.
  - RST mid-operation discards all queued and in-flight requests and restarts INIT.
- State INIT:
  - Every cycle: ram_wen=1, ram_aw=init_cnt, ram_di=INIT_VAL; init_cnt increments.
  - After the write with init_cnt=31: state <= RUN. INIT lasts exactly 32 cycles.
  - upd_valid is ignored throughout INIT.
- State RUN:
  - init_done=1. RUN persists until RST.
- Enqueue:
  - upd_ready = (state==RUN) && (free slots >= 2).
  - When upd_ready=1, each valid lane is written into the FIFO, lane 0 first.
  - upd_valid while upd_ready=0 is dropped; the sender must hold the request.
- Pop to S1:
  - If the FIFO is non-empty at cycle start, the head is popped into S1 (s1_idx, s1_inc).
  - One pop per cycle.
  - A request enqueued in cycle t is poppable no earlier than t+1.
  - Simultaneous pop and 2-lane enqueue are allowed; occupancy updates as +enq-pop.
- S1 (read):
  - ram_a = s1_idx.
  - Captured value = S2's new value if s2_valid && s2_idx==s1_idx (forward); otherwise ram_q.
  - The captured value moves to S2 with s1_idx and s1_inc.
  - ram_a is don't-care when S1 is invalid.
- S2 (modify-write):
  - ram_wen = s2_valid, ram_aw = s2_idx.
  - ram_di: if inc, min(val+1, 3); else max(val-1, 0). 2-bit saturating, no wrap.
- Latency: a request accepted in cycle t is written at the posedge ending cycle t+3 when the queue was empty. Throughput is 1 write/cycle.
- Ordering: requests to the same index apply strictly in enqueue order; back-to-back same-index updates never lose an update.
- busy = FIFO non-empty || s1_valid || s2_valid. Goes low the cycle after the last S2 write.
- ram_wen=0 in RUN whenever S2 is empty.

Test Plan:
- Init walk: RST for 1 cycle -> ram_wen=1 for 32 consecutive cycles with ram_aw 0..31 and ram_di=2'b01; init_done rises on cycle 33; upd_ready=0 until then.
- Single increment: after init, lane 0 idx=5 inc=1 -> 3 cycles later ram_wen=1, ram_aw=5, ram_di=2'b10.
- Saturation: 4 increments to idx=3 then 5 decrements to idx=3 -> RAM[3] sequence 2,3,3,3,2,1,0,0,0.
- Same-index hazard: both lanes inc idx=7 in one cycle, then lane 0 inc idx=7 -> writes 2, 3, 3 on consecutive cycles (forwarding exercised).
- Back-pressure: drive both lanes valid every cycle for 10 cycles with FIFO_DEPTH=8 -> upd_ready drops when free<2; no request lost or duplicated (write count equals accepted count); busy clears after drain.
- Reset mid-stream: assert RST while FIFO holds 5 entries -> no further RMW writes; a fresh 32-cycle INIT walk runs; busy=0.

Source files
------------

// File: rtl/opram_sat2_updater.sv
// Saturating 2-bit counter update engine for a 32x2 op-RAM write port.
// Queues up to two requests per cycle and applies them with a forwarded read-modify-write pipeline.
module opram_sat2_updater #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [1:0] INIT_VAL   = 2'b01
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] upd_valid,
    input  logic [4:0] upd_idx0,
    input  logic [4:0] upd_idx1,
    input  logic [1:0] upd_inc,
    output logic       upd_ready,
    output logic       init_done,
    output logic       busy,
    output logic [4:0] ram_a,
    input  logic [1:0] ram_q,
    output logic       ram_wen,
    output logic [4:0] ram_aw,
    output logic [1:0] ram_di
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_init_cnt;

    logic [5:0]  r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic        r_s1_valid;
    logic [4:0]  r_s1_idx;
    logic        r_s1_inc;

    logic        r_s2_valid;
    logic [4:0]  r_s2_idx;
    logic        r_s2_inc;
    logic [1:0]  r_s2_val;

    logic [CW-1:0] w_free;
    logic          w_enq0;
    logic          w_enq1;
    logic          w_pop;
    logic [PW-1:0] w_wptr1;
    logic [5:0]    w_head;
    logic [1:0]    w_s2_new;
    logic [1:0]    w_s1_val;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_INIT && r_init_cnt == 5'd31) begin
            w_state_next = ST_RUN;
        end
    end

    always_comb begin
        init_done = (r_state == ST_RUN);
        upd_ready = (r_state == ST_RUN) && (w_free >= CW'(2));
        busy      = (r_count != '0) || r_s1_valid || r_s2_valid;
        ram_a     = r_s1_idx;
        if (r_state == ST_INIT) begin
            ram_wen = 1'b1;
            ram_aw  = r_init_cnt;
            ram_di  = INIT_VAL;
        end else begin
            ram_wen = r_s2_valid;
            ram_aw  = r_s2_idx;
            ram_di  = w_s2_new;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 5'd1;
        end
    end

    // Lane 1 lands directly behind lane 0 when both are valid, preserving age order.
    assign w_free  = CW'(FIFO_DEPTH) - r_count;
    assign w_enq0  = upd_ready & upd_valid[0];
    assign w_enq1  = upd_ready & upd_valid[1];
    assign w_pop   = (r_count != '0);
    assign w_wptr1 = r_wptr + PW'(w_enq0);
    assign w_head  = r_fifo[r_rptr];

    always_ff @(posedge CLK) begin
        if (w_enq0) begin
            r_fifo[r_wptr] <= {upd_idx0, upd_inc[0]};
        end
        if (w_enq1) begin
            r_fifo[w_wptr1] <= {upd_idx1, upd_inc[1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_enq0) + PW'(w_enq1);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_count <= r_count + CW'(w_enq0) + CW'(w_enq1) - CW'(w_pop);
        end
    end

    // S2's result is not yet in the RAM while S1 reads, so a matching index takes it directly.
    assign w_s2_new = r_s2_inc ? ((r_s2_val == 2'd3) ? 2'd3 : r_s2_val + 2'd1)
                               : ((r_s2_val == 2'd0) ? 2'd0 : r_s2_val - 2'd1);
    assign w_s1_val = (r_s2_valid && r_s2_idx == r_s1_idx) ? w_s2_new : ram_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_inc   <= 1'b0;
        end else begin
            r_s1_valid <= w_pop;
            if (w_pop) begin
                r_s1_idx <= w_head[5:1];
                r_s1_inc <= w_head[0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s2_valid <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_inc   <= 1'b0;
            r_s2_val   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_idx   <= r_s1_idx;
            r_s2_inc   <= r_s1_inc;
            r_s2_val   <= w_s1_val;
        end
    end

endmodule
